// File: rtl/dual_core_write_arbiter_if.sv
// ============================================================================
// dual_core_write_arbiter_if : core write ports + shared array write port. Rev 1.0
// ============================================================================
`default_nettype none

interface dual_core_write_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          wr_valid0;
  logic          wr_ready0;
  logic [AW-1:0] wr_addr0;
  logic [DW-1:0] wr_data0;
  logic          wr_valid1;
  logic          wr_ready1;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data1;
  logic          mem_wvalid;
  logic          mem_wready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wsrc;
  logic          idle;

  modport slave (
    input  wr_valid0, wr_addr0, wr_data0,
    input  wr_valid1, wr_addr1, wr_data1,
    input  mem_wready,
    output wr_ready0, wr_ready1,
    output mem_wvalid, mem_waddr, mem_wdata, mem_wsrc, idle
  );

  modport master (
    output wr_valid0, wr_addr0, wr_data0,
    output wr_valid1, wr_addr1, wr_data1,
    output mem_wready,
    input  wr_ready0, wr_ready1,
    input  mem_wvalid, mem_waddr, mem_wdata, mem_wsrc, idle
  );
endinterface

`default_nettype wire

// File: rtl/dual_core_write_arbiter.sv
// ============================================================================
// dual_core_write_arbiter : two per-core write FIFOs, round-robin onto one
// registered array write port. Rev 1.0
// ============================================================================
`default_nettype none

module dual_core_write_arbiter #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  dual_core_write_arbiter_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    w_valid_in;
  logic [1:0]    w_ready;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_nonempty;
  logic [AW-1:0] w_addr_in   [2];
  logic [DW-1:0] w_data_in   [2];
  logic [AW-1:0] w_head_addr [2];
  logic [DW-1:0] w_head_data [2];

  logic          w_free;
  logic          w_any;
  logic          w_gnt;

  logic          r_wvalid;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_wsrc;
  logic          r_last_grant;

  assign w_valid_in   = {bus.wr_valid1, bus.wr_valid0};
  assign w_addr_in[0] = bus.wr_addr0;
  assign w_addr_in[1] = bus.wr_addr1;
  assign w_data_in[0] = bus.wr_data0;
  assign w_data_in[1] = bus.wr_data1;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [AW-1:0] r_addr_mem [DEPTH];
    logic [DW-1:0] r_data_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Ready comes from the registered count only, so it never depends on mem_wready.
    assign w_ready[g]     = (r_count != CW'(DEPTH));
    assign w_nonempty[g]  = (r_count != '0);
    assign w_push[g]      = w_valid_in[g] && w_ready[g];
    assign w_head_addr[g] = r_addr_mem[r_rptr];
    assign w_head_data[g] = r_data_mem[r_rptr];

    always_ff @(posedge clk) begin
      if (w_push[g]) begin
        r_addr_mem[r_wptr] <= w_addr_in[g];
        r_data_mem[r_wptr] <= w_data_in[g];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + PW'(1);
        if (w_pop[g])  r_rptr <= r_rptr + PW'(1);
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // With both cores pending, the one not granted last time goes next.
  always_comb begin
    w_free = !r_wvalid || bus.mem_wready;
    w_any  = |w_nonempty;
    w_gnt  = (&w_nonempty) ? ~r_last_grant : w_nonempty[1];
    w_pop  = '0;
    if (w_free && w_any) w_pop[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wvalid     <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_wsrc       <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_free) begin
      if (w_any) begin
        r_wvalid     <= 1'b1;
        r_waddr      <= w_head_addr[w_gnt];
        r_wdata      <= w_head_data[w_gnt];
        r_wsrc       <= w_gnt;
        r_last_grant <= w_gnt;
      end else begin
        r_wvalid     <= 1'b0;
      end
    end
  end

  assign bus.wr_ready0  = w_ready[0];
  assign bus.wr_ready1  = w_ready[1];
  assign bus.mem_wvalid = r_wvalid;
  assign bus.mem_waddr  = r_waddr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_wsrc   = r_wsrc;
  assign bus.idle       = !w_any && !r_wvalid;

endmodule

`default_nettype wire

// File: tb/tb_dual_core_write_arbiter.sv
// ============================================================================
// tb_dual_core_write_arbiter : scoreboard bench with a queue-based reference
// model of the two core FIFOs and the round-robin write port. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dual_core_write_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  dual_core_write_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dual_core_write_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: per-core expected writes in program order, {addr, data}.
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];

  // Reference model: FIFO occupancy per core and the write-port register.
  int m_cnt0  = 0;
  int m_cnt1  = 0;
  bit m_valid = 0;
  bit m_src   = 0;
  bit m_last  = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor + model: checks at the falling edge, then advances the model to
  // what the next rising edge should produce from the now-stable inputs.
  initial begin : monitor
    bit          stalled_prev;
    logic [15:0] prev_ad;
    logic [15:0] got;
    logic [15:0] exp_ad;
    bit          rdy0, rdy1, free, ne0, ne1, g;
    stalled_prev = 0;
    prev_ad      = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_cnt0 = 0; m_cnt1 = 0; m_valid = 0; m_src = 0; m_last = 1;
        exp_q0.delete();
        exp_q1.delete();
        stalled_prev = 0;
      end else begin
        check("wr_ready0", 32'(bus.wr_ready0), 32'(m_cnt0 != DEPTH));
        check("wr_ready1", 32'(bus.wr_ready1), 32'(m_cnt1 != DEPTH));
        check("idle", 32'(bus.idle), 32'(m_cnt0 == 0 && m_cnt1 == 0 && !m_valid));
        check("mem_wvalid", 32'(bus.mem_wvalid), 32'(m_valid));
        if (m_valid) check("mem_wsrc", 32'(bus.mem_wsrc), 32'(m_src));
        got = {bus.mem_waddr, bus.mem_wdata};
        if (stalled_prev && bus.mem_wvalid) check("hold_addr_data", 32'(got), 32'(prev_ad));
        stalled_prev = bus.mem_wvalid && !bus.mem_wready;
        prev_ad      = got;

        if (bus.mem_wvalid && bus.mem_wready) begin
          if (bus.mem_wsrc ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
            n_checks++;
            $display("FAIL sb_write: got addr %0h data %0h from core %0d, expected no write", bus.mem_waddr, bus.mem_wdata, bus.mem_wsrc);
          end else begin
            exp_ad = bus.mem_wsrc ? exp_q1.pop_front() : exp_q0.pop_front();
            check("sb_addr", 32'(bus.mem_waddr), 32'(exp_ad[15:8]));
            check("sb_data", 32'(bus.mem_wdata), 32'(exp_ad[7:0]));
          end
        end

        rdy0 = (m_cnt0 != DEPTH);
        rdy1 = (m_cnt1 != DEPTH);
        ne0  = (m_cnt0 != 0);
        ne1  = (m_cnt1 != 0);
        free = !m_valid || bus.mem_wready;
        if (free) begin
          if (ne0 || ne1) begin
            g = (ne0 && ne1) ? !m_last : ne1;
            if (g) m_cnt1--; else m_cnt0--;
            m_valid = 1; m_src = g; m_last = g;
          end else begin
            m_valid = 0;
          end
        end
        if (bus.wr_valid0 && rdy0) begin
          m_cnt0++;
          exp_q0.push_back({bus.wr_addr0, bus.wr_data0});
        end
        if (bus.wr_valid1 && rdy1) begin
          m_cnt1++;
          exp_q1.push_back({bus.wr_addr1, bus.wr_data1});
        end
      end
    end
  end

  initial begin : stimulus
    bus.wr_valid0  = 0; bus.wr_addr0 = '0; bus.wr_data0 = '0;
    bus.wr_valid1  = 0; bus.wr_addr1 = '0; bus.wr_data1 = '0;
    bus.mem_wready = 1;

    // Reset, released away from a clock edge.
    #12 reset = 1'b1;
    #1;
    check("rst_waddr", 32'(bus.mem_waddr), 32'h0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_wsrc", 32'(bus.mem_wsrc), 32'h0);
    check("rst_idle", 32'(bus.idle), 32'h1);
    cyc(2);

    // Single write.
    bus.wr_valid0 = 1; bus.wr_addr0 = 8'h37; bus.wr_data0 = 8'hA5;
    cyc();
    bus.wr_valid0 = 0;
    cyc();
    check("single_waddr", 32'(bus.mem_waddr), 32'h37);
    check("single_wdata", 32'(bus.mem_wdata), 32'hA5);
    cyc(3);

    // Simultaneous requests, then two more per core.
    bus.wr_valid0 = 1; bus.wr_addr0 = 8'h10; bus.wr_data0 = 8'h01;
    bus.wr_valid1 = 1; bus.wr_addr1 = 8'h20; bus.wr_data1 = 8'h02;
    cyc();
    for (int i = 0; i < 2; i++) begin
      bus.wr_addr0 = 8'h11 + 8'(i); bus.wr_data0 = 8'h03 + 8'(i);
      bus.wr_addr1 = 8'h21 + 8'(i); bus.wr_data1 = 8'h05 + 8'(i);
      cyc();
    end
    bus.wr_valid0 = 0; bus.wr_valid1 = 0;
    cyc(8);

    // Full FIFO behind a stalled write.
    bus.mem_wready = 0;
    bus.wr_valid0 = 1; bus.wr_addr0 = 8'h55; bus.wr_data0 = 8'h66;
    cyc();
    bus.wr_valid0 = 0;
    cyc();
    bus.wr_valid1 = 1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_addr1 = 8'h80 + 8'(i); bus.wr_data1 = 8'hC0 + 8'(i);
      cyc();
    end
    check("full_ready1", 32'(bus.wr_ready1), 32'h0);
    bus.wr_addr1 = 8'h99; bus.wr_data1 = 8'h99;
    cyc(2);
    bus.wr_valid1 = 0;
    bus.mem_wready = 1;
    cyc(8);
    check("full_ready1_back", 32'(bus.wr_ready1), 32'h1);

    // Backpressure for three cycles.
    bus.mem_wready = 0;
    bus.wr_valid0 = 1; bus.wr_addr0 = 8'hFE; bus.wr_data0 = 8'h02;
    cyc();
    bus.wr_valid0 = 0;
    cyc(4);
    check("bp_waddr", 32'(bus.mem_waddr), 32'hFE);
    check("bp_wdata", 32'(bus.mem_wdata), 32'h02);
    bus.mem_wready = 1;
    cyc(3);

    // Reset mid-operation with queued writes.
    bus.mem_wready = 0;
    bus.wr_valid0 = 1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_addr0 = 8'hA0 + 8'(i); bus.wr_data0 = 8'h30 + 8'(i);
      cyc();
    end
    bus.wr_valid0 = 0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_wvalid", 32'(bus.mem_wvalid), 32'h0);
    check("midrst_idle", 32'(bus.idle), 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    bus.mem_wready = 1;
    cyc(5);
    bus.wr_valid0 = 1; bus.wr_addr0 = 8'h01; bus.wr_data0 = 8'h11;
    bus.wr_valid1 = 1; bus.wr_addr1 = 8'h01; bus.wr_data1 = 8'h22;
    cyc();
    bus.wr_valid0 = 0; bus.wr_valid1 = 0;
    cyc();
    check("post_rst_first_src", 32'(bus.mem_wsrc), 32'h0);
    cyc(4);

    // Pointer wrap-around on core 0.
    bus.wr_valid0 = 1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_addr0 = 8'(i); bus.wr_data0 = 8'(i) ^ 8'h5A;
      cyc();
    end
    bus.wr_valid0 = 0;
    cyc(5);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid0  = 1'($urandom_range(0, 1));
      bus.wr_addr0   = 8'($urandom);
      bus.wr_data0   = 8'($urandom);
      bus.wr_valid1  = 1'($urandom_range(0, 1));
      bus.wr_addr1   = 8'($urandom);
      bus.wr_data1   = 8'($urandom);
      bus.mem_wready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    bus.wr_valid0 = 0; bus.wr_valid1 = 0; bus.mem_wready = 1;
    cyc(15);

    check("sb_drained0", 32'(exp_q0.size()), 32'h0);
    check("sb_drained1", 32'(exp_q1.size()), 32'h0);
    check("final_idle", 32'(bus.idle), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
